// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV64I-subset controller, datapath and immediate generator.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMemAcc,
        StWb,
        StTrap
    } ctrl_state_e;

    // Major opcodes (IR[6:0]) of the supported subset.
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I  = 2'b00;
    localparam logic [1:0] IMM_S  = 2'b01;
    localparam logic [1:0] IMM_SB = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_R) || (op == OP_IMM) || (op == OP_LD) ||
               (op == OP_SD) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter; wraps modulo 2^CNT_W.
module retire_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: one step per retire pulse.
    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register, cleared by asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV64I-subset datapath with memory ready handshake.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       imm_sel,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] instret
);

    ctrl_state_e state_q, state_d;

    // State register; reset returns to fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath controls; everything is held at 0 while reset is high.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_ADD;
        imm_sel    = IMM_I;
        illegal    = 1'b0;
        retire     = 1'b0;

        if (!reset) begin
            unique case (state_q)
                StFetch: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    // PC + 4 is written back the same cycle the instruction arrives.
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    if (mem_ready) begin
                        state_d = StDecode;
                    end
                end
                StDecode: begin
                    // Precompute the branch target into ALUOut.
                    alu_src_a = SRC_A_OLDPC;
                    alu_src_b = SRC_B_IMM;
                    imm_sel   = IMM_SB;
                    state_d   = is_legal_op(opcode) ? StExec : StTrap;
                end
                StExec: begin
                    alu_src_a = SRC_A_RS1;
                    unique case (opcode)
                        OP_R: begin
                            alu_op  = ALU_FUNCT;
                            state_d = StWb;
                        end
                        OP_IMM: begin
                            alu_src_b = SRC_B_IMM;
                            alu_op    = ALU_FUNCT;
                            state_d   = StWb;
                        end
                        OP_LD: begin
                            alu_src_b = SRC_B_IMM;
                            state_d   = StMemAcc;
                        end
                        OP_SD: begin
                            alu_src_b = SRC_B_IMM;
                            imm_sel   = IMM_S;
                            state_d   = StMemAcc;
                        end
                        OP_BEQ: begin
                            alu_op   = ALU_SUB;
                            pc_src   = 1'b1;
                            pc_write = zero;
                            retire   = 1'b1;
                            state_d  = StFetch;
                        end
                        default: state_d = StTrap;
                    endcase
                end
                StMemAcc: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (opcode == OP_SD);
                    if (mem_ready) begin
                        if (opcode == OP_SD) begin
                            retire  = 1'b1;
                            state_d = StFetch;
                        end else begin
                            state_d = StWb;
                        end
                    end
                end
                StWb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (opcode == OP_LD);
                    retire     = 1'b1;
                    state_d    = StFetch;
                end
                StTrap: begin
                    illegal = 1'b1;
                end
                default: state_d = StTrap;
            endcase
        end
    end

    retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire_counter (
        .clk  (clk),
        .reset(reset),
        .inc  (retire),
        .count(instret)
    );

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multi-cycle RV64I-subset datapath (R-type, I-type ALU, LD, SD, BEQ). Sequences each instruction through fetch, decode, execute, memory and writeback, drives every datapath select, including the immediate-format select consumed by the immediate generator, and handles a variable-latency memory ready handshake. It also maintains a retired-instruction counter and traps on illegal opcodes.

## Interface
- `CNT_W`, 32, width of the retired-instruction counter.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 7: `IR[6:0]`; stable from DECODE onward.
- `zero` in 1: ALU zero flag, same cycle.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write when 1; valid only with `mem_req`.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load IR and OldPC.
- `pc_write` out 1: load PC.
- `pc_src` out 1: PC input; 0 = ALU result, 1 = ALUOut.
- `reg_write` out 1: register file write enable.
- `mem_to_reg` out 1: writeback data; 0 = ALUOut, 1 = MDR.
- `alu_src_a` out 2: 00 = PC, 01 = OldPC, 10 = rs1.
- `alu_src_b` out 2: 00 = rs2, 01 = constant 4, 10 = immediate.
- `alu_op` out 2: 00 = ADD, 01 = SUB, 10 = funct-decoded.
- `imm_sel` out 2: 00 = I, 01 = S, 10 = SB.
- `illegal` out 1: sticky trap indicator.
- `retire` out 1: one-cycle pulse per completed instruction.
- `instret` out CNT_W: count of retired instructions.

## Operation
States: FETCH, DECODE, EXEC, MEMACC, WB, TRAP. Every output defaults to 0 unless listed for the current state.

- **FETCH:** `mem_req`=1, `iord`=0, `alu_src_a`=00, `alu_src_b`=01, `alu_op`=00.
  - Stays in FETCH while `mem_ready`=0.
  - On `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0, then go to DECODE.
- **DECODE:** `alu_src_a`=01, `alu_src_b`=10, `imm_sel`=10, `alu_op`=00, so ALUOut holds the branch target.
  - Opcodes 0110011, 0010011, 0000011, 0100011, 1100011 go to EXEC.
  - Any other opcode goes to TRAP.
- **EXEC, by opcode:**
  - R-type: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10, then WB.
  - I-type ALU: same as R-type with `alu_src_b`=10, `imm_sel`=00, then WB.
  - LD: `alu_src_a`=10, `alu_src_b`=10, `imm_sel`=00, `alu_op`=00, then MEMACC.
  - SD: same as LD with `imm_sel`=01, then MEMACC.
  - BEQ: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `pc_src`=1, `pc_write`=`zero`, `retire`=1, then FETCH.
- **MEMACC:** `mem_req`=1, `iord`=1, `mem_we`=1 for SD.
  - Stays in MEMACC while `mem_ready`=0.
  - On `mem_ready`=1: SD asserts `retire`=1 and goes to FETCH; LD goes to WB.
- **WB:** `reg_write`=1, `mem_to_reg`=1 for LD else 0, `retire`=1, then FETCH.
- **TRAP:** `illegal`=1, all other outputs 0. Absorbing; only `reset` leaves it.
- **`instret`:** increments by 1 on each `retire` cycle; wraps modulo 2^CNT_W.

## Timing
- **Reset:** `reset` high asynchronously forces state to FETCH and `instret` to 0. While `reset`=1, all outputs are forced to 0, including `mem_req`. The first `mem_req` appears in the first cycle after release.
- **Output style:** outputs are combinational from state and `opcode`. `ir_write`, `pc_write` and `retire` also depend on `mem_ready` or `zero` in the same cycle (Mealy).
- **Zero-wait memory latency:** BEQ 3 cycles, R/I/SD 4 cycles, LD 5 cycles. Each wait cycle adds one.
- **Handshake rules:**
  - `mem_req` holds with a stable `iord`/`mem_we` until the `mem_ready` cycle.
  - `mem_ready` in the same cycle as a new `mem_req` completes the access in that cycle.
  - `mem_ready` outside FETCH/MEMACC is ignored.
- **Reset mid-access:** abandons the access with no retire; `instret` is cleared.
- **Counter wrap:** `retire` in the same cycle `instret` = all-ones yields 0.

## Structure
- Package `riscv_ctrl_pkg`: state enum; opcode constants (OP_R, OP_IMM, OP_LD, OP_SD, OP_BEQ); `alu_op`, `imm_sel`, `alu_src_a`, `alu_src_b` encodings. The datapath and immediate generator share these.
- Sub-module `retire_counter`: CNT_W-bit counter with `clk`, `reset`, `inc` inputs and a `count` output.
- Top level: state register plus the next-state/output logic.

## Test plan
- **Add, zero-wait memory:** `opcode`=0110011, `mem_ready`=1 throughout → states FETCH, DECODE, EXEC, WB; `reg_write`=1 and `mem_to_reg`=0 in WB; `instret` 0→1 after cycle 4.
- **Load, wait states:** `opcode`=0000011, `mem_ready` low for 2 cycles in FETCH and 3 in MEMACC → 10 cycles total; `iord`=1 and `mem_we`=0 in MEMACC; `mem_to_reg`=1 in WB.
- **BEQ taken and not taken:**
  - `zero`=1 in EXEC → `pc_write`=1, `pc_src`=1, `retire`=1.
  - `zero`=0 → `pc_write`=0, `retire`=1.
  - Both cases take 3 cycles.
- **Illegal opcode:** `opcode`=1111111 → TRAP after DECODE; `illegal`=1 and every other output 0 for 20 cycles; `instret` unchanged.
- **Reset mid-MEMACC of SD:** `instret` cleared and all outputs 0 during reset; `mem_req`=1 with `iord`=0 in the first cycle after release.
- **Counter wrap:** CNT_W=4 with 16 back-to-back BEQs → `instret` returns to 0.
